// File: rtl/axistream_width_downsizer_pkg.sv
// Shared width helpers for the AXI-stream width converters (downsizer, FIFO, upsizer).
package axistream_width_downsizer_pkg;

   // Counter width for a 0..value-1 index; never narrower than one bit.
   function automatic int axis_clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int axis_ow(input int in_width, input int ratio);
      return in_width / ratio;
   endfunction

endpackage

// File: rtl/axistream_width_downsizer.sv
// Splits each IN_WIDTH word into RATIO narrow beats; beat 0 one cycle after the load,
// next word loads on the last beat's handshake (no bubble); dest stalls hold word and index.
module axistream_width_downsizer
   import axistream_width_downsizer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int RATIO     = 4,
   parameter bit MSB_FIRST = 1'b0,
   localparam int OW       = axis_ow(IN_WIDTH, RATIO),
   localparam int BW       = axis_clog2(RATIO)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                src_tvalid,
   output logic                src_tready,
   input  logic [IN_WIDTH-1:0] src_tdata,
   input  logic                src_tlast,
   output logic                dest_tvalid,
   input  logic                dest_tready,
   output logic [OW-1:0]       dest_tdata,
   output logic                dest_tlast,
   output logic                busy
);

   localparam logic [BW-1:0] LAST_IDX = BW'(RATIO - 1);

   generate
      if ((IN_WIDTH % RATIO) != 0 || RATIO < 2 || RATIO > 256) begin : g_bad_params
         $error("axistream_width_downsizer: IN_WIDTH must be a multiple of RATIO, RATIO in 2..256");
      end
   endgenerate

   logic [IN_WIDTH-1:0] r_word;
   logic                r_last;
   logic                r_full;
   logic [BW-1:0]       r_beat_idx;

   logic                w_last_beat;
   logic                w_load;
   logic                w_dest_hs;
   logic [BW-1:0]       w_slice;

   // Explicit compare so a non power-of-two RATIO never runs past its last slice.
   assign w_last_beat = (r_beat_idx == LAST_IDX);
   assign src_tready  = rst_n && (!r_full || (dest_tready && w_last_beat));
   assign w_load      = src_tvalid && src_tready;
   assign w_dest_hs   = r_full && dest_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full     <= 1'b0;
         r_last     <= 1'b0;
         r_beat_idx <= '0;
      end else if (w_load) begin
         r_full     <= 1'b1;
         r_last     <= src_tlast;
         r_beat_idx <= '0;
      end else if (w_dest_hs) begin
         if (w_last_beat) begin
            r_full     <= 1'b0;
            r_beat_idx <= '0;
         end else begin
            r_beat_idx <= r_beat_idx + 1'b1;
         end
      end
   end

   // Payload needs no reset: it is only observable while r_full is set.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_word <= src_tdata;
      end
   end

   assign w_slice = MSB_FIRST ? (LAST_IDX - r_beat_idx) : r_beat_idx;

   always_comb begin
      dest_tdata = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (w_slice == BW'(i)) begin
            dest_tdata = r_word[i*OW +: OW];
         end
      end
   end

   assign dest_tvalid = r_full;
   assign dest_tlast  = r_full && r_last && w_last_beat;
   assign busy        = r_full;

endmodule
